// File: rtl/booth_r4_pkg.sv
// Shared types and constants for the Booth radix-4 multiplier scheduler.
// Build option: SKIP_ZERO_EN (bypass the ADD state for zero recode digits).
package booth_r4_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadQ,
    StAdd,
    StShift,
    StOutHi,
    StOutLo,
    StDone
  } state_e;

  typedef enum logic [2:0] {
    DigZero,
    DigPosM,
    DigPos2M,
    DigNegM,
    DigNeg2M
  } digit_e;

  localparam int unsigned NumStrobes = 8;
  localparam int unsigned IdxC0 = 0;
  localparam int unsigned IdxC1 = 1;
  localparam int unsigned IdxC2 = 2;
  localparam int unsigned IdxC3 = 3;
  localparam int unsigned IdxC4 = 4;
  localparam int unsigned IdxC5 = 5;
  localparam int unsigned IdxC6 = 6;
  localparam int unsigned IdxC7 = 7;

  // {Q[1],Q[0],Q[-1]} -> radix-4 Booth digit
  function automatic digit_e recode(input logic [2:0] bits);
    digit_e dig;
    case (bits)
      3'b001, 3'b010: dig = DigPosM;
      3'b011:         dig = DigPos2M;
      3'b100:         dig = DigNeg2M;
      3'b101, 3'b110: dig = DigNegM;
      default:        dig = DigZero;
    endcase
    return dig;
  endfunction

  function automatic logic is_zero_digit(input logic [2:0] bits);
    return (bits == 3'b000) || (bits == 3'b111);
  endfunction

endpackage

// File: rtl/booth_r4_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr+1 with wrap.
// The caller registers the result and moves ptr to the winner.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    valid
);

  localparam int unsigned IdW = $clog2(NREQ);

  always_comb begin
    int unsigned idx;
    idx    = 0;
    gnt    = '0;
    gnt_id = '0;
    valid  = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!valid && req[IdW'(idx)]) begin
        valid            = 1'b1;
        gnt[IdW'(idx)]   = 1'b1;
        gnt_id           = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/booth_r4_sched.sv
// Round-robin sequencer driving the strobes of a shared Booth radix-4 multiplier datapath.
// Build option: SKIP_ZERO_EN skips the ADD state when the upcoming recode digit is zero.
module booth_r4_sched
  import booth_r4_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [2:0]              q_lsb,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    busy,
  output logic                    c0,
  output logic                    c1,
  output logic                    c2,
  output logic                    c3,
  output logic                    c4,
  output logic                    c5,
  output logic                    c6,
  output logic                    c7,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id
);

  localparam int unsigned ITER = WIDTH / 2;
  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(ITER + 1);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [IdW-1:0]        gnt_id_q, gnt_id_d;
  logic [IdW-1:0]        ptr_q, ptr_d;
  logic [NREQ-1:0]       pick_gnt;
  logic [IdW-1:0]        pick_id;
  logic                  pick_valid;
  logic [NumStrobes-1:0] strobe;
  state_e                iter_state;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .gnt_id(pick_id),
    .valid (pick_valid)
  );

  // Entry state for the next recode digit
`ifdef SKIP_ZERO_EN
  assign iter_state = is_zero_digit(q_lsb) ? StShift : StAdd;
`else
  assign iter_state = StAdd;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d    = pick_gnt;
          gnt_id_d = pick_id;
          ptr_d    = pick_id;
          state_d  = StLoadA;
        end
      end
      StLoadA: begin
        cnt_d   = '0;
        state_d = StLoadQ;
      end
      StLoadQ: state_d = iter_state;
      StAdd:   state_d = StShift;
      StShift: begin
        cnt_d   = cnt_q + CntW'(1);
        state_d = (cnt_q == CntW'(ITER - 1)) ? StOutHi : iter_state;
      end
      StOutHi: state_d = StOutLo;
      StOutLo: state_d = StDone;
      StDone: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= IdW'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    strobe = '0;
    unique case (state_q)
      StLoadA: strobe[IdxC0] = 1'b1;
      StLoadQ: strobe[IdxC1] = 1'b1;
      StAdd: begin
        case (recode(q_lsb))
          DigPosM:  strobe[IdxC2] = 1'b1;
          DigPos2M: strobe[IdxC3] = 1'b1;
          DigNegM:  {strobe[IdxC4], strobe[IdxC2]} = 2'b11;
          DigNeg2M: {strobe[IdxC4], strobe[IdxC3]} = 2'b11;
          default:  strobe = '0;
        endcase
      end
      StShift: strobe[IdxC5] = 1'b1;
      StOutHi: strobe[IdxC6] = 1'b1;
      StOutLo: strobe[IdxC7] = 1'b1;
      default: strobe = '0;
    endcase
  end

  assign c0      = strobe[IdxC0];
  assign c1      = strobe[IdxC1];
  assign c2      = strobe[IdxC2];
  assign c3      = strobe[IdxC3];
  assign c4      = strobe[IdxC4];
  assign c5      = strobe[IdxC5];
  assign c6      = strobe[IdxC6];
  assign c7      = strobe[IdxC7];
  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign done_id = done ? gnt_id_q : '0;

endmodule

// File: tb/tb_booth_r4_sched.sv
// Self-checking bench for booth_r4_sched: slot-list reference model plus done_id scoreboard.
// Honours SKIP_ZERO_EN when the bench is built with it.
module tb_booth_r4_sched;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned ITER  = WIDTH / 2;
  localparam int unsigned IdW   = $clog2(NREQ);

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [2:0]      q_lsb;
  logic [NREQ-1:0] gnt;
  logic [IdW-1:0]  gnt_id, done_id;
  logic            busy, done;
  logic            c0, c1, c2, c3, c4, c5, c6, c7;

  always #5 clk = ~clk;

  booth_r4_sched #(
    .NREQ (NREQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .q_lsb  (q_lsb),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .c0     (c0),
    .c1     (c1),
    .c2     (c2),
    .c3     (c3),
    .c4     (c4),
    .c5     (c5),
    .c6     (c6),
    .c7     (c7),
    .done   (done),
    .done_id(done_id)
  );

  typedef enum {SLoadA, SLoadQ, SAdd, SShift, SOutHi, SOutLo, SDone} slot_e;

  int          n_tests = 0;
  int          n_fail  = 0;
  slot_e       slots[$];
  int unsigned exp_ids[$];
  int unsigned m_ptr = NREQ - 1;
  int unsigned m_id  = 0;
  logic [2:0]  qprev = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobes from the signed digit value -2*b2 + b1 + b0, bit i = c<i>
  function automatic logic [7:0] digit_strobes(input logic [2:0] b);
    int d;
    d = -2 * int'(b[2]) + int'(b[1]) + int'(b[0]);
    case (d)
      1:       return 8'b0000_0100;
      2:       return 8'b0000_1000;
      -1:      return 8'b0001_0100;
      -2:      return 8'b0001_1000;
      default: return 8'b0000_0000;
    endcase
  endfunction

  // Reference model: evaluated once per cycle, away from the rising edge
  always @(negedge clk) begin
    logic [7:0]      c_exp, c_act;
    logic [NREQ-1:0] g_exp;
    logic            b_exp, d_exp;
    c_act = {c7, c6, c5, c4, c3, c2, c1, c0};
    if (!reset) begin
      check("reset_outputs", 32'({busy, done, c_act, gnt, gnt_id, done_id}), 32'd0);
      slots.delete();
      exp_ids.delete();
      m_ptr = NREQ - 1;
    end else begin
`ifdef SKIP_ZERO_EN
      if (slots.size() > 0 && slots[0] == SAdd && (qprev == 3'b000 || qprev == 3'b111))
        void'(slots.pop_front());
`endif
      c_exp = '0;
      d_exp = 1'b0;
      g_exp = '0;
      b_exp = (slots.size() != 0);
      if (b_exp) begin
        g_exp[m_id] = 1'b1;
        case (slots[0])
          SLoadA:  c_exp[0] = 1'b1;
          SLoadQ:  c_exp[1] = 1'b1;
          SAdd:    c_exp = digit_strobes(q_lsb);
          SShift:  c_exp[5] = 1'b1;
          SOutHi:  c_exp[6] = 1'b1;
          SOutLo:  c_exp[7] = 1'b1;
          default: d_exp = 1'b1;
        endcase
        check("gnt_id", 32'(gnt_id), m_id);
      end
      check("busy_done_strobes_gnt", 32'({busy, done, c_act, gnt}),
            32'({b_exp, d_exp, c_exp, g_exp}));
      if (b_exp) begin
        void'(slots.pop_front());
      end else if (|req) begin
        for (int unsigned i = 1; i <= NREQ; i++) begin
          if (req[(m_ptr + i) % NREQ]) begin
            m_id = (m_ptr + i) % NREQ;
            break;
          end
        end
        m_ptr = m_id;
        exp_ids.push_back(m_id);
        slots.push_back(SLoadA);
        slots.push_back(SLoadQ);
        for (int unsigned k = 0; k < ITER; k++) begin
          slots.push_back(SAdd);
          slots.push_back(SShift);
        end
        slots.push_back(SOutHi);
        slots.push_back(SOutLo);
        slots.push_back(SDone);
      end
    end
    qprev = q_lsb;
  end

  // Scoreboard monitor: each done pulse retires the oldest granted requester
  always @(negedge clk) begin
    if (reset && done) begin
      if (exp_ids.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_unexpected: got done_id %0d, expected no done (t=%0t)", done_id,
                 $time);
      end else begin
        check("done_id", 32'(done_id), exp_ids.pop_front());
      end
    end
  end

  task automatic idle_cycles(input int n);
    req = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    q_lsb = 3'b000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Single requester, constant +M digit
    @(posedge clk);
    #1 req = 2'b01;
    q_lsb = 3'b001;
    repeat (14) @(posedge clk);
    #1 idle_cycles(4);

    // Each non-trivial digit held through a whole operation
    for (int p = 0; p < 8; p++) begin
      req = 2'b10;
      q_lsb = 3'(p);
      repeat (14) @(posedge clk);
      #1 idle_cycles(3);
    end

    // Requester drops in the middle of its own operation
    req = 2'b01;
    q_lsb = 3'b110;
    repeat (5) @(posedge clk);
    #1 idle_cycles(16);

    // Both held: strict alternation
    req = '1;
    repeat (4 * 14 + 4) @(posedge clk);
    #1 idle_cycles(20);

    // Asynchronous reset while the operation is in its shift phase
    req = 2'b10;
    q_lsb = 3'b011;
    repeat (4) @(posedge clk);
    #3 reset = 1'b0;
    #1 check("async_reset_immediate",
             32'({busy, done, c7, c6, c5, c4, c3, c2, c1, c0, gnt, gnt_id, done_id}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    req = '1;
    repeat (30) @(posedge clk);
    #1;

    // Randomised requests and recode bits
    for (int cyc = 0; cyc < 1500; cyc++) begin
      q_lsb = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) req = NREQ'($urandom);
      @(posedge clk);
      #1;
    end
    idle_cycles(20);

    // Zero digits throughout
    req = 2'b01;
    q_lsb = 3'b000;
    repeat (10) @(posedge clk);
    #1 q_lsb = 3'b111;
    req = 2'b10;
    repeat (12) @(posedge clk);
    #1 idle_cycles(20);

    check("scoreboard_drained", exp_ids.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
